// File: rtl/rtc_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rtc_access_arbiter_pkg
// Shared definitions for the RTC access arbiter: FSM state encoding and the
// default refresh / timeout periods used as parameter defaults by the top.
// -----------------------------------------------------------------------------
package rtc_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int REFRESH_CYCLES_DEF = 100000;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/rtc_access_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rtc_access_arbiter_rr_pick  (rr_pick)
// Combinational round-robin winner selection. Scans requesters starting at
// i_rr_ptr, wrapping NREQ-1 -> 0, and reports the first one asserted.
//
// Ports
//   i_req     [NREQ-1:0]  request levels
//   i_rr_ptr  [IW-1:0]    index with highest priority this round
//   o_valid               at least one request present
//   o_index   [IW-1:0]    winning requester index (0 when o_valid is low)
// -----------------------------------------------------------------------------
module rtc_access_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_rr_ptr,
  output logic            o_valid,
  output logic [IW-1:0]   o_index
);

  // Scan from the farthest offset down to offset 0 so the candidate closest
  // to the pointer is the last one written and therefore wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = int'(i_rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (i_req[IW'(j)]) begin
        o_valid = 1'b1;
        o_index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rtc_access_arbiter.sv
// -----------------------------------------------------------------------------
// rtc_access_arbiter
// Shares one RTC access engine between NREQ external requesters and an
// internal periodic time/date refresh requester. A pending refresh always
// wins; external requesters are served round-robin. Each transaction runs
// START (one-cycle start pulse) -> WAIT (until engine ready) -> RELEASE.
//
// Optional feature: define RTC_ARB_TIMEOUT_EN to bound the WAIT phase to
// TIMEOUT_CYCLES cycles; on expiry the sticky o_timeout_err is set and the
// grant is released. Without the macro WAIT is unbounded and
// o_timeout_err is tied low.
//
// Ports
//   i_clk                 system clock, rising edge
//   i_rst_n               asynchronous active-low reset
//   i_req     [NREQ-1:0]  level requests, held until own grant bit seen
//   o_grant   [NREQ:0]    one-hot grant, bit NREQ = internal refresh
//   o_start               one-cycle engine launch pulse
//   i_ready               engine done pulse, honoured in WAIT only
//   o_busy                high whenever the FSM is not idle
//   o_timeout_err         sticky grant-timeout flag
//
// state   | meaning
// IDLE    | no grant; pick refresh or round-robin winner
// START   | grant + start pulse, ready ignored
// WAIT    | grant held until ready (or timeout)
// RELEASE | grant dropped for one cycle, advance rr pointer
// -----------------------------------------------------------------------------
module rtc_access_arbiter
  import rtc_access_arbiter_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ:0]   o_grant,
  output logic            o_start,
  input  logic            i_ready,
  output logic            o_busy,
  output logic            o_timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NREQ:0]   r_grant;
  logic [NREQ:0]   w_grant_nxt;
  logic            r_start;
  logic            r_busy;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_win_idx;
  logic            r_win_ref;
  logic            w_win_load;
  logic            w_ref_take;
  logic            w_timeout_hit;
  logic            w_wait_expired;
  logic            w_pick_valid;
  logic [IW-1:0]   w_pick_idx;
  logic [RW-1:0]   r_ref_cnt;
  logic            r_ref_pend;
  logic            w_ref_wrap;

  rtc_access_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_index  (w_pick_idx)
  );

  // Free-running refresh period counter.
  assign w_ref_wrap = (r_ref_cnt == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ref_cnt <= '0;
    end else if (w_ref_wrap) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  // Set has priority over clear: a wrap coinciding with the refresh grant
  // queues the next refresh, and repeated wraps never stack beyond one.
  // Pending out of reset so the first refresh follows reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ref_pend <= 1'b1;
    end else if (w_ref_wrap) begin
      r_ref_pend <= 1'b1;
    end else if (w_ref_take) begin
      r_ref_pend <= 1'b0;
    end
  end

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout_err;

  // Cleared outside WAIT, so it reads 0 in the first WAIT cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_wait_expired = (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout_hit) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_wait_expired   = 1'b0;
  assign o_timeout_err    = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ref_take    = 1'b0;
    w_win_load    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        if (r_ref_pend) begin
          w_state_nxt       = ST_START;
          w_ref_take        = 1'b1;
          w_win_load        = 1'b1;
          w_grant_nxt[NREQ] = 1'b1;
        end else if (w_pick_valid) begin
          w_state_nxt = ST_START;
          w_win_load  = 1'b1;
          w_grant_nxt = (NREQ + 1)'(1) << w_pick_idx;
        end
      end
      ST_START: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Ready checked first so a simultaneous ready never flags a timeout.
        if (i_ready) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = '0;
        end else if (w_wait_expired) begin
          w_state_nxt   = ST_RELEASE;
          w_grant_nxt   = '0;
          w_timeout_hit = 1'b1;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant   <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_rr_ptr  <= '0;
      r_win_idx <= '0;
      r_win_ref <= 1'b0;
    end else begin
      r_grant <= w_grant_nxt;
      r_start <= (w_state_nxt == ST_START);
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_win_load) begin
        r_win_idx <= w_pick_idx;
        r_win_ref <= w_ref_take;
      end
      // Refresh transactions leave the external rotation untouched.
      if (r_state == ST_RELEASE && !r_win_ref) begin
        r_rr_ptr <= (r_win_idx == IW'(NREQ - 1)) ? '0 : r_win_idx + 1'b1;
      end
    end
  end

  assign o_grant = r_grant;
  assign o_start = r_start;
  assign o_busy  = r_busy;

endmodule
